// File: rtl/ipf_seq_ctrl.sv
// ipf_seq_ctrl: sequences input/weight memory reads and IPF commands per group/pass; watchdog enabled by IPF_SEQ_WATCHDOG_EN
module ipf_seq_ctrl #(
  parameter int I_WORDS  = 8,
  parameter int W_DEPTH  = 9,
  parameter int W_FIRST  = 5,
  parameter int W_NEXT   = 4,
  parameter int COMP_CYC = 32,
  parameter int GROUPS   = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        i_rd,
  output logic [3:0]  i_addr,
  input  logic [63:0] i_rdata,
  output logic        w_rd,
  output logic [3:0]  w_addr,
  input  logic [63:0] w_rdata,
  output logic        i_valid,
  output logic [63:0] i_data,
  output logic        w_valid,
  output logic [63:0] w_data,
  output logic [2:0]  ctrl,
  input  logic        res_valid,
  input  logic        finish,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  res_cnt
);
`ifdef IPF_SEQ_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_W, COMPUTE, NEXT, WAIT_FIN, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] cnt, w_len;
  logic [3:0] i_ptr, w_ptr;
  logic [7:0] group;
  logic pass, fin_seen, err_q, wd_hit;
  always_comb begin
    w_len = pass ? 16'(W_NEXT) : 16'(W_FIRST);
    wd_hit = WD_EN && state == WAIT_FIN && cnt == 16'(TIMEOUT - 1);
    state_nx = state;
    case (state)
      IDLE:     state_nx = start ? LOAD_I : IDLE;
      LOAD_I:   state_nx = cnt == 16'(I_WORDS - 1) ? LOAD_W : LOAD_I;
      // one extra LOAD_W cycle lets the last weight word drain before ctrl=1
      LOAD_W:   state_nx = cnt == w_len ? COMPUTE : LOAD_W;
      COMPUTE:  state_nx = cnt == 16'(COMP_CYC - 1) ? NEXT : COMPUTE;
      NEXT:     state_nx = !pass ? LOAD_W : group == 8'(GROUPS - 1) ? WAIT_FIN : LOAD_I;
      WAIT_FIN: state_nx = (finish || fin_seen || wd_hit) ? DONE : WAIT_FIN;
      default:  state_nx = IDLE;
    endcase
    busy = state != IDLE;
    done = state == DONE;
    i_rd = state == LOAD_I;
    w_rd = state == LOAD_W && cnt < w_len;
    i_addr = i_rd ? i_ptr : '0;
    w_addr = w_rd ? w_ptr : '0;
    ctrl = state == COMPUTE ? 3'd1 : (state == NEXT || (state == LOAD_W && pass)) ? 3'd2 : 3'd0;
    i_data = i_valid ? i_rdata : '0;
    w_data = w_valid ? w_rdata : '0;
    err = WD_EN & err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      i_ptr <= '0;
      w_ptr <= '0;
      group <= '0;
      pass <= 1'b0;
      fin_seen <= 1'b0;
      err_q <= 1'b0;
      i_valid <= 1'b0;
      w_valid <= 1'b0;
      res_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= state_nx != state ? '0 : cnt + 16'd1;
      i_valid <= i_rd;
      w_valid <= w_rd;
      if (i_rd) i_ptr <= i_ptr + 4'd1;
      if (w_rd) w_ptr <= w_ptr == 4'(W_DEPTH - 1) ? '0 : w_ptr + 4'd1;
      if (state == NEXT) begin
        pass <= !pass;
        if (pass) group <= group + 8'd1;
      end
      if (busy && finish) fin_seen <= 1'b1;
      if (busy && res_valid && res_cnt != 8'hFF) res_cnt <= res_cnt + 8'd1;
      if (wd_hit) err_q <= 1'b1;
      if (state == IDLE && start) begin
        i_ptr <= '0;
        w_ptr <= '0;
        group <= '0;
        pass <= 1'b0;
        fin_seen <= 1'b0;
        err_q <= 1'b0;
        res_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ipf_seq_ctrl.sv
// tb_ipf_seq_ctrl: directed scenario tasks against ipf_seq_ctrl with behavioral memories
module tb_ipf_seq_ctrl;
  localparam int N = 4400;
  logic clk = 0, rst = 1, start = 0, res_valid = 0, finish = 0;
  logic i_rd, w_rd, i_valid, w_valid, busy, done, err;
  logic [3:0] i_addr, w_addr;
  logic [63:0] i_rdata, w_rdata, i_data, w_data;
  logic [2:0] ctrl;
  logic [7:0] res_cnt;
  int vec = 0, errs = 0;
  logic r_iv[N], r_wv[N], r_ird[N], r_wrd[N], r_busy[N], r_done[N], r_err[N];
  logic [2:0] r_ctrl[N];
  logic [3:0] r_ia[N], r_wa[N];
  logic [7:0] r_rc[N];
  logic [63:0] r_id[N], r_wd[N];

  ipf_seq_ctrl dut (.clk(clk), .rst(rst), .start(start), .i_rd(i_rd), .i_addr(i_addr), .i_rdata(i_rdata),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata), .i_valid(i_valid), .i_data(i_data), .w_valid(w_valid),
    .w_data(w_data), .ctrl(ctrl), .res_valid(res_valid), .finish(finish), .busy(busy), .done(done), .err(err),
    .res_cnt(res_cnt));

  always #5 clk = ~clk;

  // memories return a marker word when not read so gating to zero is observable
  always @(posedge clk) begin
    i_rdata <= i_rd ? 64'h1000 + 64'(i_addr) : 64'hDEAD_BEEF;
    w_rdata <= w_rd ? 64'h2000 + 64'(w_addr) : 64'hDEAD_BEEF;
  end

  task automatic run_job(input int n, input int fin_at, input int rst_at, input int st2_at, input int rv_hi);
    for (int c = 0; c < n; c++) begin
      start = (c == 0) || (c == st2_at);
      finish = (c == fin_at);
      rst = (c == rst_at);
      res_valid = (c >= 1 && c <= rv_hi);
      #1;
      r_iv[c] = i_valid; r_wv[c] = w_valid; r_ird[c] = i_rd; r_wrd[c] = w_rd;
      r_busy[c] = busy; r_done[c] = done; r_err[c] = err; r_ctrl[c] = ctrl;
      r_ia[c] = i_addr; r_wa[c] = w_addr; r_rc[c] = res_cnt; r_id[c] = i_data; r_wd[c] = w_data;
      @(negedge clk);
    end
    {start, finish, rst, res_valid} = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    logic [159:0] got;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      #1;
      got = {i_rd, w_rd, i_valid, w_valid, busy, done, err, ctrl, res_cnt, i_addr, w_addr, i_data, w_data};
      vec++;
      if (got !== '0) begin errs++; $display("FAIL reset k=%0d got=%h exp=0", k, got); end
      @(negedge clk);
    end
  endtask

  task automatic test_first_pass();
    logic [133:0] got, exp;
    logic iv, wv;
    run_job(60, -1, -1, -1, 0);
    for (int c = 0; c <= 53; c++) begin
      iv = c >= 2 && c <= 9;
      wv = (c >= 10 && c <= 14) || (c >= 49 && c <= 52);
      exp = {iv, wv, c < 15 ? 3'd0 : c < 47 ? 3'd1 : c < 53 ? 3'd2 : 3'd1, c >= 1,
             iv ? 64'h1000 + 64'(c - 2) : 64'h0,
             !wv ? 64'h0 : c <= 14 ? 64'h2000 + 64'(c - 10) : 64'h2000 + 64'(c - 44)};
      got = {r_iv[c], r_wv[c], r_ctrl[c], r_busy[c], r_id[c], r_wd[c]};
      vec++;
      if (got !== exp) begin errs++; $display("FAIL first_pass c=%0d got=%h exp=%h", c, got, exp); end
    end
    vec++;
    if (r_rc[1] !== 8'd0) begin errs++; $display("FAIL res_clear got=%0d exp=0", r_rc[1]); end
    do_reset();
  endtask

  task automatic test_full_job();
    int ni = 0, nw = 0, np = 0, nov = 0, nd = 0;
    run_job(182, 176, -1, -1, 0);
    for (int c = 0; c < 182; c++) begin
      if (r_iv[c]) begin
        vec++;
        if (r_id[c] !== 64'h1000 + 64'(ni)) begin errs++; $display("FAIL full_i c=%0d got=%h exp=%h", c, r_id[c], 64'h1000 + 64'(ni)); end
        ni++;
      end
      if (r_wv[c]) begin
        vec++;
        if (r_wd[c] !== 64'h2000 + 64'(nw % 9)) begin errs++; $display("FAIL full_w c=%0d got=%h exp=%h", c, r_wd[c], 64'h2000 + 64'(nw % 9)); end
        nw++;
      end
      if (c > 0 && r_ctrl[c] == 3'd2 && r_ctrl[c-1] != 3'd2) np++;
      if (r_iv[c] && r_wv[c]) nov++;
      if (r_done[c]) nd++;
    end
    vec += 6;
    if (ni !== 16) begin errs++; $display("FAIL full_icount got=%0d exp=16", ni); end
    if (nw !== 18) begin errs++; $display("FAIL full_wcount got=%0d exp=18", nw); end
    if (np !== 4) begin errs++; $display("FAIL full_next_pulses got=%0d exp=4", np); end
    if (nov !== 0) begin errs++; $display("FAIL full_overlap got=%0d exp=0", nov); end
    if (nd !== 1) begin errs++; $display("FAIL full_done_count got=%0d exp=1", nd); end
    if ({r_done[177], r_busy[177], r_busy[178]} !== 3'b110) begin
      errs++; $display("FAIL full_done_busy got=%b exp=110", {r_done[177], r_busy[177], r_busy[178]});
    end
  endtask

  task automatic test_reset_mid();
    logic [160:0] got;
    run_job(40, -1, 35, -1, 0);
    vec++;
    if (r_ctrl[35] !== 3'd1) begin errs++; $display("FAIL mid_pre got=%0d exp=1", r_ctrl[35]); end
    for (int c = 36; c < 40; c++) begin
      got = {r_iv[c], r_wv[c], r_ird[c], r_wrd[c], r_ctrl[c], r_busy[c], r_done[c], r_err[c], r_rc[c], r_ia[c], r_wa[c], r_id[c], r_wd[c]};
      vec++;
      if (got !== '0) begin errs++; $display("FAIL mid_reset c=%0d got=%h exp=0", c, got); end
    end
    test_first_pass();
  endtask

  task automatic test_early_finish();
    int ni = 0;
    run_job(176, 110, -1, -1, 0);
    for (int c = 0; c < 176; c++) ni += int'(r_iv[c]);
    vec += 4;
    if (ni !== 16) begin errs++; $display("FAIL early_icount got=%0d exp=16", ni); end
    if (r_ctrl[111] !== 3'd1 || r_ctrl[170] !== 3'd2) begin
      errs++; $display("FAIL early_ctrl got=%0d,%0d exp=1,2", r_ctrl[111], r_ctrl[170]);
    end
    if ({r_busy[171], r_done[171], r_done[172]} !== 3'b101) begin
      errs++; $display("FAIL early_exit got=%b exp=101", {r_busy[171], r_done[171], r_done[172]});
    end
    if (r_busy[173] !== 1'b0) begin errs++; $display("FAIL early_idle got=%b exp=0", r_busy[173]); end
  endtask

  task automatic test_back_to_back();
    int ni = 0;
    run_job(405, 400, -1, 50, 300);
    for (int c = 0; c < 405; c++) ni += int'(r_iv[c]);
    vec += 7;
    if (r_rc[100] !== 8'd99) begin errs++; $display("FAIL res_mid got=%0d exp=99", r_rc[100]); end
    if (r_rc[301] !== 8'd255) begin errs++; $display("FAIL res_sat got=%0d exp=255", r_rc[301]); end
    if (r_rc[402] !== 8'd255) begin errs++; $display("FAIL res_hold got=%0d exp=255", r_rc[402]); end
    if (ni !== 16) begin errs++; $display("FAIL restart_icount got=%0d exp=16", ni); end
    if (r_ctrl[60] !== 3'd1) begin errs++; $display("FAIL restart_ctrl got=%0d exp=1", r_ctrl[60]); end
    if ({r_done[400], r_done[401]} !== 2'b01) begin errs++; $display("FAIL b2b_done got=%b exp=01", {r_done[400], r_done[401]}); end
    if (r_busy[402] !== 1'b0) begin errs++; $display("FAIL b2b_idle got=%b exp=0", r_busy[402]); end
  endtask

  task automatic test_watchdog();
    int nd = 0;
    run_job(4300, -1, -1, -1, 0);
    for (int c = 0; c < 4300; c++) nd += int'(r_done[c]);
`ifdef IPF_SEQ_WATCHDOG_EN
    vec += 4;
    if ({r_done[4266], r_done[4267]} !== 2'b01) begin errs++; $display("FAIL wd_done got=%b exp=01", {r_done[4266], r_done[4267]}); end
    if ({r_err[4266], r_err[4267], r_err[4299]} !== 3'b011) begin
      errs++; $display("FAIL wd_err got=%b exp=011", {r_err[4266], r_err[4267], r_err[4299]});
    end
    if (r_busy[4268] !== 1'b0) begin errs++; $display("FAIL wd_idle got=%b exp=0", r_busy[4268]); end
    if (nd !== 1) begin errs++; $display("FAIL wd_done_count got=%0d exp=1", nd); end
`else
    vec += 3;
    if ({r_busy[4299], r_err[4299]} !== 2'b10) begin errs++; $display("FAIL nowd_wait got=%b exp=10", {r_busy[4299], r_err[4299]}); end
    if (nd !== 0) begin errs++; $display("FAIL nowd_done_count got=%0d exp=0", nd); end
    if (r_ctrl[4299] !== 3'd0) begin errs++; $display("FAIL nowd_ctrl got=%0d exp=0", r_ctrl[4299]); end
`endif
    do_reset();
    #1;
    vec++;
    if ({busy, err} !== 2'b00) begin errs++; $display("FAIL wd_reset got=%b exp=00", {busy, err}); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_pass();
    test_full_job();
    test_reset_mid();
    test_early_finish();
    test_back_to_back();
    test_first_pass();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/ipf_seq_ctrl.md
IPF_SEQ_CTRL -- requirements
Module: ipf_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: I_WORDS 8, input words per group; W_DEPTH 9, weight memory depth; W_FIRST 5, weight words in first pass; W_NEXT 4, weight words in second pass; COMP_CYC 32, compute cycles per pass; GROUPS 2, groups per job; TIMEOUT 4096, finish watchdog limit.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  job request, sampled in IDLE only.
REQ-005 i_rd / i_addr  out  1 / 4  input-memory read strobe and word address; sync read, 1-cycle latency.
REQ-006 i_rdata  in  64  input-memory read data.
REQ-007 w_rd / w_addr  out  1 / 4  weight-memory read strobe and word address; sync read, 1-cycle latency.
REQ-008 w_rdata  in  64  weight-memory read data.
REQ-009 i_valid / i_data  out  1 / 64  input stream to IPF.
REQ-010 w_valid / w_data  out  1 / 64  weight stream to IPF.
REQ-011 ctrl  out  3  IPF command: 0 idle/end, 1 run, 2 next-pass; other codes never driven.
REQ-012 res_valid / finish  in  1 / 1  IPF result strobe and job-complete flag.
REQ-013 busy, done, err, res_cnt  out  1, 1, 1, 8  job active; one-cycle completion pulse; watchdog error; result count.

Function
REQ-014 States SHALL be IDLE, LOAD_I, LOAD_W, COMPUTE, NEXT, WAIT_FIN, DONE.
REQ-015 IDLE->LOAD_I when start=1; busy=1 in all states except IDLE; start while busy SHALL be ignored.
REQ-016 LOAD_I: i_rd=1 for exactly I_WORDS consecutive cycles, i_addr incrementing from group*I_WORDS; then LOAD_W.
REQ-017 LOAD_W: w_rd=1 for W_FIRST cycles (first pass of group) or W_NEXT cycles (second pass), w_addr incrementing and wrapping W_DEPTH-1 -> 0; w_addr persists across passes, cleared only at job start.
REQ-018 i_valid/w_valid SHALL be i_rd/w_rd delayed one cycle; i_data/w_data SHALL equal i_rdata/w_rdata while valid, 0 otherwise; i_valid and w_valid never high together.
REQ-019 First w_rd SHALL be the cycle after last i_rd, so the w_valid burst immediately follows the i_valid burst without gap.
REQ-020 COMPUTE: ctrl=1 from the cycle after the last w_valid, held COMP_CYC cycles; then NEXT.
REQ-021 NEXT: ctrl=2 for one cycle; ctrl SHALL remain 2 through a following LOAD_W until COMPUTE; after second pass, next group LOAD_I, or WAIT_FIN after group GROUPS-1.
REQ-022 WAIT_FIN: ctrl=0; exit to DONE on finish=1; finish seen any cycle since job start SHALL be latched and cause exit in the cycle after entry.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 res_cnt SHALL increment per res_valid cycle while busy, saturate at 255, clear at job start.

Reset
REQ-025 rst=1 at any clock edge, including mid-job, SHALL force IDLE next cycle with ctrl=0, all strobes/valids=0, data=0, addresses=0, busy=done=err=0, res_cnt=0, finish latch cleared.
REQ-026 No partial read burst SHALL continue after reset; i_valid may only follow an i_rd issued before that reset edge if that edge was not a reset edge.

Configuration
REQ-027 Macro IPF_SEQ_WATCHDOG_EN defined: counter runs in WAIT_FIN; reaching TIMEOUT cycles without finish SHALL set err=1 (sticky until next start or rst) and go to DONE.
REQ-028 Macro undefined: no counter, err tied 0, WAIT_FIN waits indefinitely.

Verification
REQ-029 Reset then start pulse at cycle 0 -> i_valid cycles 2-9 (addr 0-7), w_valid cycles 10-14 (addr 0-4), ctrl=1 cycles 15-46, ctrl=2 cycle 47.
REQ-030 Full default job, finish pulsed 5 cycles after WAIT_FIN entry -> 16 input words, 18 weight words (addr sequence 0-8 twice), four ctrl=2 pulses, done one cycle, busy falls next cycle.
REQ-031 rst asserted during cycle 20 of first COMPUTE -> next cycle all outputs 0, state IDLE; new start replays REQ-029 timing exactly.
REQ-032 finish asserted early during second group COMPUTE -> no effect on sequence; WAIT_FIN exits one cycle after entry.
REQ-033 With IPF_SEQ_WATCHDOG_EN, finish never asserted -> err=1 and done pulse after 4096 WAIT_FIN cycles; without macro, busy stays 1.
REQ-034 300 res_valid pulses during a job -> res_cnt=255; start pressed while busy -> no restart.
